// File: rtl/alu_share_arbiter_if.sv
// Request/response handshake bundle for one requester of the shared ALU.
// The requester side uses the master modport, the arbiter the slave modport.
interface alu_share_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  aluop;
  logic        sign;
  logic [31:0] data1;
  logic [31:0] op2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] result;
  logic        zero;
  logic        neg;

  modport master (
    output req_valid, aluop, sign, data1, op2, rsp_ready,
    input  req_ready, rsp_valid, result, zero, neg
  );

  modport slave (
    input  req_valid, aluop, sign, data1, op2, rsp_ready,
    output req_ready, rsp_valid, result, zero, neg
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one combinational ALU between two requesters,
// with a registered response slot per port. Define ALU_ARB_STATS_EN for counters.
module alu_share_arbiter #(
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_share_arbiter_if.slave   port0,
  alu_share_arbiter_if.slave   port1,
  output logic [4:0]           alu_aluop,
  output logic                 alu_sign,
  output logic [31:0]          alu_data1,
  output logic [31:0]          alu_op2,
  input  logic [31:0]          alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_neg
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNTW-1:0]      stat_grant0,
  output logic [CNTW-1:0]      stat_grant1,
  output logic [CNTW-1:0]      stat_conflict
`endif
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam logic [4:0] LAST_LEGAL_OP = 5'b01001;

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic [1:0]  accept;
  logic        last_q;

  slot_state_t state_q [2];
  slot_state_t state_d [2];
  logic [31:0] result_q [2];
  logic [1:0]  zero_q;
  logic [1:0]  neg_q;

  logic        illegal;
  logic [31:0] cap_result;
  logic        cap_zero;
  logic        cap_neg;

  assign req_valid = {port1.req_valid, port0.req_valid};
  assign rsp_ready = {port1.rsp_ready, port0.rsp_ready};
  assign rsp_valid = {state_q[1] == SLOT_FULL, state_q[0] == SLOT_FULL};

  // A port may issue when its slot is empty or being drained this cycle.
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  assign accept = grant & {2{~reset}};

  always_comb begin
    alu_aluop = '0;
    alu_sign  = 1'b0;
    alu_data1 = '0;
    alu_op2   = '0;
    if (grant[0]) begin
      alu_aluop = port0.aluop;
      alu_sign  = port0.sign;
      alu_data1 = port0.data1;
      alu_op2   = port0.op2;
    end else if (grant[1]) begin
      alu_aluop = port1.aluop;
      alu_sign  = port1.sign;
      alu_data1 = port1.data1;
      alu_op2   = port1.op2;
    end
  end

  // Undefined opcodes never expose whatever the ALU happens to produce.
  assign illegal    = alu_aluop > LAST_LEGAL_OP;
  assign cap_result = illegal ? 32'd0 : alu_result;
  assign cap_zero   = illegal ? 1'b1  : alu_zero;
  assign cap_neg    = illegal ? 1'b0  : alu_neg;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (accept[0]) begin
      last_q <= 1'b0;
    end else if (accept[1]) begin
      last_q <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        SLOT_EMPTY: if (accept[i]) state_d[i] = SLOT_FULL;
        SLOT_FULL: begin
          if (accept[i])         state_d[i] = SLOT_FULL;
          else if (rsp_ready[i]) state_d[i] = SLOT_EMPTY;
        end
        default: state_d[i] = SLOT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) state_q[i] <= SLOT_EMPTY;
      else       state_q[i] <= state_d[i];
    end
  end

  // NOTE: the response data registers are reset too, since their value is
  // visible on the ports straight out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        result_q[i] <= '0;
        zero_q[i]   <= 1'b0;
        neg_q[i]    <= 1'b0;
      end else if (accept[i]) begin
        result_q[i] <= cap_result;
        zero_q[i]   <= cap_zero;
        neg_q[i]    <= cap_neg;
      end
    end
  end

  assign port0.req_ready = accept[0];
  assign port0.rsp_valid = rsp_valid[0];
  assign port0.result    = result_q[0];
  assign port0.zero      = zero_q[0];
  assign port0.neg       = neg_q[0];

  assign port1.req_ready = accept[1];
  assign port1.rsp_valid = rsp_valid[1];
  assign port1.result    = result_q[1];
  assign port1.zero      = zero_q[1];
  assign port1.neg       = neg_q[1];

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (accept[0] && stat_grant0 != CNT_MAX)       stat_grant0   <= stat_grant0 + CNT_ONE;
      if (accept[1] && stat_grant1 != CNT_MAX)       stat_grant1   <= stat_grant1 + CNT_ONE;
      if ((elig == 2'b11) && stat_conflict != CNT_MAX) stat_conflict <= stat_conflict + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: behavioural ALU, directed sequences
// and a per-port scoreboard of expected responses.
module tb_alu_share_arbiter;

  localparam int CNTW = 16;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        neg;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  alu_aluop;
  logic        alu_sign;
  logic [31:0] alu_data1;
  logic [31:0] alu_op2;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_neg;
`ifdef ALU_ARB_STATS_EN
  logic [CNTW-1:0] stat_grant0;
  logic [CNTW-1:0] stat_grant1;
  logic [CNTW-1:0] stat_conflict;
`endif

  int checks   = 0;
  int failures = 0;

  rsp_t exp_q0[$];
  rsp_t exp_q1[$];

  alu_share_arbiter_if p0();
  alu_share_arbiter_if p1();

  alu_share_arbiter #(.CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .port0      (p0),
    .port1      (p1),
    .alu_aluop  (alu_aluop),
    .alu_sign   (alu_sign),
    .alu_data1  (alu_data1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Bench ALU; undefined opcodes return junk so forcing can be observed.
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a << b[4:0];
      5'd3: return a >> b[4:0];
      5'd4: return $unsigned($signed(a) >>> b[4:0]);
      5'd5: return a & b;
      5'd6: return a | b;
      5'd7: return a ^ b;
      5'd8: return sgn ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
      5'd9: return b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic rsp_t expect_rsp(input logic [4:0] op, input logic sgn,
                                      input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    if (op > 5'd9) begin
      r.result = 32'd0;
      r.zero   = 1'b1;
      r.neg    = 1'b0;
    end else begin
      r.result = alu_fn(op, sgn, a, b);
      r.zero   = (r.result == 32'd0);
      r.neg    = r.result[31];
    end
    return r;
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_aluop, alu_sign, alu_data1, alu_op2);
    alu_zero   = (alu_result == 32'd0);
    alu_neg    = alu_result[31];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: consume before accept so a same-cycle refill queues behind the old entry.
  always @(negedge clk) begin
    rsp_t e;
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (p0.rsp_valid && p0.rsp_ready) begin
        if (exp_q0.size() == 0) check("sb0_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q0.pop_front();
          check("sb0_result", p0.result, e.result);
          check("sb0_zero", {31'd0, p0.zero}, {31'd0, e.zero});
          check("sb0_neg", {31'd0, p0.neg}, {31'd0, e.neg});
        end
      end
      if (p1.rsp_valid && p1.rsp_ready) begin
        if (exp_q1.size() == 0) check("sb1_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q1.pop_front();
          check("sb1_result", p1.result, e.result);
          check("sb1_zero", {31'd0, p1.zero}, {31'd0, e.zero});
          check("sb1_neg", {31'd0, p1.neg}, {31'd0, e.neg});
        end
      end
      if (p0.req_valid && p0.req_ready)
        exp_q0.push_back(expect_rsp(p0.aluop, p0.sign, p0.data1, p0.op2));
      if (p1.req_valid && p1.req_ready)
        exp_q1.push_back(expect_rsp(p1.aluop, p1.sign, p1.data1, p1.op2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [4:0] op, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b);
    p0.req_valid = v; p0.aluop = op; p0.sign = sgn; p0.data1 = a; p0.op2 = b;
  endtask

  task automatic drive1(input logic v, input logic [4:0] op, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b);
    p1.req_valid = v; p1.aluop = op; p1.sign = sgn; p1.data1 = a; p1.op2 = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    drive0(1'b1, 5'd0, 1'b0, 32'd1, 32'd2);
    drive1(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    p0.rsp_ready = 1'b1;
    p1.rsp_ready = 1'b1;
    tick();
    tick();

    // Reset state; a request presented during reset is not accepted.
    #1;
    check("rst_ready0", {31'd0, p0.req_ready}, 32'd0);
    check("rst_valid0", {31'd0, p0.rsp_valid}, 32'd0);
    check("rst_valid1", {31'd0, p1.rsp_valid}, 32'd0);
    check("rst_result0", p0.result, 32'd0);
    check("rst_flags0", {30'd0, p0.zero, p0.neg}, 32'd0);
    check("rst_result1", p1.result, 32'd0);
`ifdef ALU_ARB_STATS_EN
    check("rst_conflict", 32'(stat_conflict), 32'd0);
`endif
    drive0(1'b0, 5'd7, 1'b1, 32'd9, 32'd9);
    reset = 1'b0;
    #1;
    check("idle_aluop", {27'd0, alu_aluop}, 32'd0);
    check("idle_data1", alu_data1, 32'd0);

    // Single op: 5 + (-7).
    do_reset();
    drive0(1'b1, 5'd0, 1'b0, 32'd5, 32'hFFFF_FFF9);
    #1;
    check("single_ready0", {31'd0, p0.req_ready}, 32'd1);
    check("single_alu_op2", alu_op2, 32'hFFFF_FFF9);
    tick();
    drive0(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    check("single_valid0", {31'd0, p0.rsp_valid}, 32'd1);
    check("single_result0", p0.result, 32'hFFFF_FFFE);
    check("single_zero0", {31'd0, p0.zero}, 32'd0);
    check("single_neg0", {31'd0, p0.neg}, 32'd1);
    tick();
    check("single_drained0", {31'd0, p0.rsp_valid}, 32'd0);

    // Conflict fairness from reset: 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 5'd1, 1'b1, 32'(100 + i), 32'(i));
      drive1(1'b1, 5'd1, 1'b1, 32'(200 + i), 32'(3 * i));
      #1;
      check("fair_ready0", {31'd0, p0.req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("fair_ready1", {31'd0, p1.req_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
`ifdef ALU_ARB_STATS_EN
    check("fair_conflict", 32'(stat_conflict), 32'd4);
    check("fair_grant0", 32'(stat_grant0), 32'd2);
    check("fair_grant1", 32'(stat_grant1), 32'd2);
`endif
    drive0(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    drive1(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();

    // Backpressure on rsp0 does not block port 1.
    p0.rsp_ready = 1'b0;
    drive0(1'b1, 5'd0, 1'b0, 32'd10, 32'd20);
    #1;
    check("bp_first_ready0", {31'd0, p0.req_ready}, 32'd1);
    tick();
    drive0(1'b1, 5'd0, 1'b0, 32'd7, 32'd8);
    drive1(1'b1, 5'd2, 1'b0, 32'd1, 32'd4);
    #1;
    check("bp_ready0", {31'd0, p0.req_ready}, 32'd0);
    check("bp_ready1", {31'd0, p1.req_ready}, 32'd1);
    check("bp_hold_a", p0.result, 32'd30);
    tick();
    drive1(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    check("bp_sll_result1", p1.result, 32'd16);
    check("bp_valid1", {31'd0, p1.rsp_valid}, 32'd1);
    check("bp_hold_b", p0.result, 32'd30);
    check("bp_still_valid0", {31'd0, p0.rsp_valid}, 32'd1);
    tick();
    check("bp_hold_c", p0.result, 32'd30);
    p0.rsp_ready = 1'b1;
    #1;
    check("bp_release_ready0", {31'd0, p0.req_ready}, 32'd1);
    tick();
    check("bp_new_result0", p0.result, 32'd15);

    // Drain and refill in the same cycle.
    drive0(1'b1, 5'd1, 1'b1, 32'd3, 32'd4);
    #1;
    check("refill_ready0", {31'd0, p0.req_ready}, 32'd1);
    tick();
    drive0(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    check("refill_valid0", {31'd0, p0.rsp_valid}, 32'd1);
    check("refill_result0", p0.result, 32'hFFFF_FFFF);
    check("refill_neg0", {31'd0, p0.neg}, 32'd1);
    tick();

    // Illegal opcode on port 1.
    drive1(1'b1, 5'b01111, 1'b0, 32'd123, 32'd456);
    #1;
    check("illegal_ready1", {31'd0, p1.req_ready}, 32'd1);
    tick();
    drive1(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    check("illegal_result1", p1.result, 32'd0);
    check("illegal_zero1", {31'd0, p1.zero}, 32'd1);
    check("illegal_neg1", {31'd0, p1.neg}, 32'd0);
    tick();

    // Reset with both slots full; then first conflict goes to port 0.
    p0.rsp_ready = 1'b0;
    p1.rsp_ready = 1'b0;
    drive0(1'b1, 5'd0, 1'b0, 32'd1, 32'd1);
    tick();
    drive0(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    drive1(1'b1, 5'd0, 1'b0, 32'd2, 32'd2);
    tick();
    check("mid_full0", {31'd0, p0.rsp_valid}, 32'd1);
    check("mid_full1", {31'd0, p1.rsp_valid}, 32'd1);
    drive0(1'b1, 5'd6, 1'b0, 32'hF0, 32'h0F);
    drive1(1'b1, 5'd7, 1'b0, 32'hFF, 32'h0F);
    p0.rsp_ready = 1'b1;
    p1.rsp_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("mid_rst_ready0", {31'd0, p0.req_ready}, 32'd0);
    check("mid_rst_ready1", {31'd0, p1.req_ready}, 32'd0);
    tick();
    reset = 1'b0;
    check("mid_valid0", {31'd0, p0.rsp_valid}, 32'd0);
    check("mid_valid1", {31'd0, p1.rsp_valid}, 32'd0);
    check("mid_result1", p1.result, 32'd0);
`ifdef ALU_ARB_STATS_EN
    check("mid_grant0", 32'(stat_grant0), 32'd0);
    check("mid_conflict", 32'(stat_conflict), 32'd0);
`endif
    #1;
    check("post_rst_ready0", {31'd0, p0.req_ready}, 32'd1);
    check("post_rst_ready1", {31'd0, p1.req_ready}, 32'd0);
    tick();
    check("post_rst_valid0", {31'd0, p0.rsp_valid}, 32'd1);
    check("post_rst_valid1", {31'd0, p1.rsp_valid}, 32'd0);
    check("post_rst_turn1", {31'd0, p1.req_ready}, 32'd1);
    tick();
    drive0(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    drive1(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);

    budget = 20;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check("sb0_leftover", 32'(exp_q0.size()), 32'd0);
    check("sb1_leftover", 32'(exp_q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Two-port arbiter that time-shares the single execute-stage ALU between two requesters:
  - port 0: the pipeline execute path;
  - port 1: an auxiliary requester, e.g. address/CSR computation.
- Each port uses a valid/ready request handshake and a registered valid/ready response.
- The block sits between the requesters and the combinational ALU: it drives the ALU operands from the granted request and captures the result one cycle later.
- Arbitration is round-robin, with at most one ALU operation accepted per cycle.

## Interface
Parameters:
- CNTW, 16, width of the statistics counters (used only with ALU_ARB_STATS_EN)

Ports (clock is `clk`; reset is `reset`, synchronous and active-high; one clock domain):
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous active-high reset
- reqN_valid  in  1  request N valid (N = 0, 1)
- reqN_ready  out  1  request N accepted this cycle
- reqN_aluop  in  5  ALU opcode, 5'b00000..5'b01001 legal
- reqN_sign  in  1  signed/unsigned select for sub/slt
- reqN_data1  in  32  operand 1
- reqN_op2  in  32  operand 2 / shamt in [4:0]
- rspN_valid  out  1  response N held valid
- rspN_ready  in  1  response N consumed
- rspN_result  out  32  registered ALU result
- rspN_zero  out  1  registered zero flag
- rspN_neg  out  1  registered negative flag
- alu_aluop, alu_sign, alu_data1, alu_op2  out  5/1/32/32  operands to the ALU
- alu_result, alu_zero, alu_neg  in  32/1/1  combinational ALU outputs, same cycle
- stat_grant0, stat_grant1, stat_conflict  out  CNTW each  present only with ALU_ARB_STATS_EN

## Operation
- **Eligibility:** eligN = reqN_valid & (!rspN_valid | rspN_ready). A request can be accepted when its response slot is empty or is draining in the same cycle.
- **Grant selection:**
  - Exactly one eligible port: that port is granted.
  - Both eligible: the port opposite `last` is granted.
  - No port eligible: no grant.
- **Ready:** reqN_ready = grantN & !reset. Acceptance is reqN_valid & reqN_ready, at most one port per cycle.
- **ALU drive:**
  - With a grant: alu_* outputs carry the granted port's fields combinationally.
  - Without a grant: alu_aluop = 0, alu_sign = 0, alu_data1 = 0, alu_op2 = 0.
- **Capture on acceptance at edge k:**
  - rspN_result/zero/neg <= alu_result/zero/neg.
  - rspN_valid <= 1.
  - `last` <= N.
- **Illegal opcode** (aluop > 5'b01001): the request is accepted normally. The response is forced to result = 0, zero = 1, neg = 0, and the ALU output is ignored.
- **Response slot FSM per port, EMPTY -> FULL -> EMPTY:**
  - FULL holds the result, zero and neg values stable until rspN_valid & rspN_ready.
  - Consume with no new accept: the slot goes EMPTY.
  - Consume and accept for the same port in the same cycle: the slot stays FULL with the new data.
- The two ports are independent: a stalled rsp1 never blocks port 0.

## Timing
- **Reset values:**
  - reqN_ready = 0, rspN_valid = 0.
  - rspN_result = 0, rspN_zero = 0, rspN_neg = 0.
  - `last` = 1, so port 0 wins the first conflict.
  - Counters = 0.
- **Reset mid-operation:** pending responses are dropped, and requests presented in the reset cycle are not accepted.
- **Latency:** request accepted at edge k -> rspN_valid high from edge k, visible in cycle k+1.
- **Throughput:** one accept per cycle aggregate. A single port sustains 1/cycle if rspN_ready stays high.
- Request fields are sampled only in the accept cycle. They need not be held afterwards.
- **Valid rules:**
  - reqN_valid may drop without acceptance; there is no transaction.
  - rspN_valid never drops without rspN_ready.
- **Path constraint:** ALU inputs and outputs form a combinational loop-free path: req -> alu_* -> alu_result -> rsp register.

## Configuration
- **ALU_ARB_STATS_EN defined:**
  - stat_grant0/1 increment on each accept by port 0/1.
  - stat_conflict increments on each cycle with elig0 & elig1.
  - All counters saturate at 2^CNTW-1 and clear on reset.
- **ALU_ARB_STATS_EN undefined:** the counter ports and logic are absent. Arbitration behaviour is identical.

## Test plan
- **Single op:** reset, then req0 add data1 = 5, op2 = -7 -> req0_ready same cycle. Next cycle rsp0_valid = 1, result = 0xFFFFFFFE, zero = 0, neg = 1.
- **Conflict fairness:** both ports present sub continuously with rsp ready = 1 -> grants alternate 0, 1, 0, 1 starting with port 0. stat_conflict = 4 after 4 cycles (stats build).
- **Backpressure:** rsp0_ready = 0 with rsp0 FULL and req0_valid high -> req0_ready = 0 and the rsp0 data is held stable. Port 1 sll data1 = 1, op2 = 4 is still accepted with result 16. Raising rsp0_ready accepts req0 the same cycle.
- **Drain-and-refill:** rsp0_ready = 1 and req0 accepted in the same cycle -> rsp0_valid stays 1 and the next cycle shows the new result.
- **Illegal opcode:** aluop = 5'b01111 -> accepted, response result = 0, zero = 1, neg = 0.
- **Reset mid-flight:** with both responses FULL, assert reset one cycle -> all rsp_valid = 0 and counters = 0. A conflict in the first cycle after reset grants port 0.
